// File: rtl/inner_sched_pkg.sv
// inner_sched_pkg: FSM encoding and default FIFO sizing shared by the scheduler and its result FIFO
package inner_sched_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2, DONE = 2'd3} state_t;
  localparam int FIFO_DEPTH_DEF = 8;
  localparam int CNT_W = $clog2(FIFO_DEPTH_DEF + 1);
  localparam int PTR_W = $clog2(FIFO_DEPTH_DEF);
endpackage

// File: rtl/inner_sched_fifo.sv
// inner_sched_fifo: synchronous result FIFO with count/full/empty and a register-array head output
// Ports: clock/aclr_n (async active-low reset), i_push/i_din write side, i_pop read side
// (ignored when empty), o_dout head entry, o_count occupancy, o_full/o_empty flags.
module inner_sched_fifo
  import inner_sched_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH_DEF,
  parameter int W = 32,
  parameter int CW = CNT_W,
  parameter int PW = PTR_W
) (
  input  logic          clock,
  input  logic          aclr_n,
  input  logic          i_push,
  input  logic [W-1:0]  i_din,
  input  logic          i_pop,
  output logic [W-1:0]  o_dout,
  output logic [CW-1:0] o_count,
  output logic          o_full,
  output logic          o_empty
);
  logic [W-1:0] r_mem [DEPTH];
  logic [PW-1:0] r_wr, r_rd;
  logic [CW-1:0] r_cnt;
  logic w_push, w_pop;
  assign o_empty = r_cnt == '0;
  assign o_full = r_cnt == CW'(DEPTH);
  assign w_push = i_push && !o_full;
  assign w_pop = i_pop && !o_empty;
  assign o_count = r_cnt;
  assign o_dout = r_mem[r_rd];
  always_ff @(posedge clock or negedge aclr_n) begin
    if (!aclr_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wr <= '0;
      r_rd <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr] <= i_din;
        r_wr <= r_wr + 1'b1;
      end
      if (w_pop) r_rd <= r_rd + 1'b1;
      r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
    end
  end
endmodule

// File: rtl/inner_function_scheduler.sv
// inner_function_scheduler: credit-gated issue sequencer and result collector for the fixed-latency inner_function pipeline
// Ports: clock/aclr_n (async active-low reset); cmd_start/cmd_len job command; in_valid/in_data/in_ready
// operand stream; fu_clk_en/fu_start/fu_dataa/fu_result/fu_done pipeline side; out_valid/out_data/out_ready
// result stream; busy, job_done (one-cycle pulse), err (sticky).
// Optional INNER_SCHED_DONE_CHECK_EN: compares fu_done with the internal capture tap and latches err.
module inner_function_scheduler
  import inner_sched_pkg::*;
#(
  parameter int LATENCY = 31,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
  parameter int LEN_W = 16
) (
  input  logic             clock,
  input  logic             aclr_n,
  input  logic             cmd_start,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic             in_valid,
  input  logic [31:0]      in_data,
  output logic             in_ready,
  output logic             fu_clk_en,
  output logic             fu_start,
  output logic [31:0]      fu_dataa,
  input  logic [31:0]      fu_result,
  input  logic             fu_done,
  output logic             out_valid,
  output logic [31:0]      out_data,
  input  logic             out_ready,
  output logic             busy,
  output logic             job_done,
  output logic             err
);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int OW = CW + 1;
  state_t r_state, w_next;
  logic [LEN_W-1:0] r_len, r_issue;
  logic [LATENCY-1:0] r_vpipe;
  logic [CW-1:0] r_inflight, w_cnt;
  logic [OW-1:0] w_occ;
  logic w_acc, w_cap, w_pop, w_empty, w_unused_full;
  // Credit counts results already promised to the FIFO; a same-cycle pop only frees credit next cycle.
  assign w_occ = OW'(r_inflight) + OW'(w_cnt);
  assign w_acc = in_valid && in_ready;
  assign w_cap = r_vpipe[LATENCY-1];
  assign w_pop = out_ready && out_valid;
  assign out_valid = !w_empty;
  always_ff @(posedge clock or negedge aclr_n) begin
    if (!aclr_n) r_state <= IDLE;
    else r_state <= w_next;
  end
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: w_next = cmd_start ? ((cmd_len == '0) ? DONE : RUN) : IDLE;
      RUN: w_next = (r_issue == r_len) ? DRAIN : RUN;
      DRAIN: w_next = (!(|r_vpipe) && w_empty && !w_pop) ? DONE : DRAIN;
      default: w_next = IDLE;
    endcase
  end
  always_comb begin
    busy = r_state != IDLE;
    job_done = r_state == DONE;
    in_ready = (r_state == RUN) && (r_issue < r_len) && (w_occ < OW'(FIFO_DEPTH));
  end
  always_ff @(posedge clock or negedge aclr_n) begin
    if (!aclr_n) begin
      r_len <= '0;
      r_issue <= '0;
      r_vpipe <= '0;
      r_inflight <= '0;
      fu_start <= 1'b0;
      fu_dataa <= '0;
      fu_clk_en <= 1'b0;
    end else begin
      fu_clk_en <= 1'b1;
      if (r_state == IDLE && cmd_start) begin
        r_len <= cmd_len;
        r_issue <= '0;
      end else if (w_acc) r_issue <= r_issue + 1'b1;
      r_vpipe <= {r_vpipe[LATENCY-2:0], w_acc};
      r_inflight <= r_inflight + CW'(w_acc) - CW'(w_cap);
      fu_start <= w_acc;
      if (w_acc) fu_dataa <= in_data;
    end
  end
  inner_sched_fifo #(.DEPTH(FIFO_DEPTH), .W(32), .CW(CW), .PW($clog2(FIFO_DEPTH))) u_fifo (
    .clock(clock),
    .aclr_n(aclr_n),
    .i_push(w_cap),
    .i_din(fu_result),
    .i_pop(out_ready),
    .o_dout(out_data),
    .o_count(w_cnt),
    .o_full(w_unused_full),
    .o_empty(w_empty)
  );
`ifdef INNER_SCHED_DONE_CHECK_EN
  logic r_err;
  always_ff @(posedge clock or negedge aclr_n) begin
    if (!aclr_n) r_err <= 1'b0;
    else r_err <= r_err | (fu_done ^ w_cap);
  end
  assign err = r_err;
`else
  logic w_unused_done;
  assign w_unused_done = fu_done;
  assign err = 1'b0;
`endif
endmodule

// File: tb/tb_inner_function_scheduler.sv
// tb_inner_function_scheduler: scoreboard bench with a behavioural fixed-latency pipeline model
module tb_inner_function_scheduler;
  localparam int LAT = 31;
  logic clock = 1'b0;
  logic aclr_n, cmd_start, in_valid, in_ready, fu_clk_en, fu_start, fu_done;
  logic out_valid, out_ready, busy, job_done, err;
  logic [15:0] cmd_len;
  logic [31:0] in_data, fu_dataa, fu_result, out_data;
  inner_function_scheduler #(.LATENCY(LAT), .FIFO_DEPTH(8), .LEN_W(16)) dut (
    .clock(clock), .aclr_n(aclr_n), .cmd_start(cmd_start), .cmd_len(cmd_len),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .fu_clk_en(fu_clk_en), .fu_start(fu_start), .fu_dataa(fu_dataa),
    .fu_result(fu_result), .fu_done(fu_done),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .busy(busy), .job_done(job_done), .err(err)
  );
  always #5 clock = ~clock;
  int n_vec = 0, n_err = 0, cyc = 0;
  int n_start, first_s, last_s, first_ov, n_busy, n_jd, jd_cyc, n_pop, last_pop;
  int g_cnt = 0, early_at = -1;
  logic [31:0] fq[$];
  logic [31:0] eq[$];
  // Pipeline model: result and done visible in the cycle the scheduler's capture tap is high.
  logic p_v [LAT-1];
  logic p_e [LAT-1];
  logic [31:0] p_d [LAT-1];
  assign fu_result = p_v[LAT-2] ? p_d[LAT-2] + 32'h0100_0000 : 32'hDEAD_BEEF;
  assign fu_done = (p_v[LAT-2] & !p_e[LAT-2]) | (p_v[LAT-3] & p_e[LAT-3]);
  always @(posedge clock or negedge aclr_n) begin
    if (!aclr_n) begin
      for (int k = 0; k < LAT - 1; k++) begin
        p_v[k] <= 1'b0;
        p_e[k] <= 1'b0;
        p_d[k] <= '0;
      end
    end else begin
      p_v[0] <= fu_start;
      p_d[0] <= fu_dataa;
      p_e[0] <= fu_start && (g_cnt == early_at);
      g_cnt <= g_cnt + (fu_start ? 1 : 0);
      for (int k = 1; k < LAT - 1; k++) begin
        p_v[k] <= p_v[k-1];
        p_d[k] <= p_d[k-1];
        p_e[k] <= p_e[k-1];
      end
    end
  end
  always @(posedge clock) cyc <= cyc + 1;
  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clock);
    #1;
  endtask
  task automatic feed(logic [31:0] x);
    fq.push_back(x);
    eq.push_back(x + 32'h0100_0000);
  endtask
  task automatic clr();
    n_start = 0; first_s = -1; last_s = -1; first_ov = -1;
    n_busy = 0; n_jd = 0; jd_cyc = -1; n_pop = 0; last_pop = -1;
  endtask
  task automatic start(logic [15:0] len);
    cmd_len = len;
    cmd_start = 1'b1;
    tick();
    cmd_start = 1'b0;
  endtask
  task automatic wait_jd(int lim);
    int i = 0;
    while (n_jd == 0 && i < lim) begin
      tick();
      i++;
    end
    chk("job_done_timeout", n_jd > 0, 1);
  endtask
  task automatic wait_start(int n, int lim);
    int i = 0;
    while (n_start < n && i < lim) begin
      tick();
      i++;
    end
    chk("issue_timeout", n_start >= n, 1);
  endtask
  // Operand feeder: holds in_valid while operands are queued, advances on handshake.
  initial begin
    logic hs;
    in_valid = 1'b0;
    in_data = '0;
    forever begin
      @(negedge clock);
      hs = in_valid && in_ready;
      @(posedge clock);
      #1;
      if (hs && fq.size() > 0) void'(fq.pop_front());
      in_valid = fq.size() > 0;
      in_data = in_valid ? fq[0] : '0;
    end
  end
  // Monitor: event counters and scoreboard comparison on every output handshake.
  initial begin
    clr();
    forever begin
      @(negedge clock);
      if (aclr_n) begin
        if (fu_start) begin
          n_start++;
          if (first_s < 0) first_s = cyc;
          last_s = cyc;
        end
        if (out_valid && first_ov < 0) first_ov = cyc;
        if (busy) n_busy++;
        if (job_done) begin
          n_jd++;
          jd_cyc = cyc;
        end
        if (out_valid && out_ready) begin
          n_pop++;
          last_pop = cyc;
          if (eq.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_result: got %0h expected none", out_data);
          end else chk("result", out_data, eq.pop_front());
        end
      end
    end
  end
  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
  initial begin
    int s;
    aclr_n = 1'b0;
    cmd_start = 1'b0;
    cmd_len = '0;
    out_ready = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    chk("reset_ctrl", {in_ready, fu_start, out_valid, busy, job_done, err, fu_clk_en}, 0);
    chk("reset_data", fu_dataa | out_data, 0);
    aclr_n = 1'b1;
    tick();
    chk("clk_en_after_reset", fu_clk_en, 1);
    chk("idle_not_busy", {busy, in_ready}, 0);
    // Back-to-back job of 4
    clr();
    out_ready = 1'b1;
    feed(32'h3F80_0000); feed(32'h4000_0000); feed(32'h42FE_0000); feed(32'h0000_0000);
    start(16'd4);
    wait_jd(200);
    repeat (3) tick();
    chk("b2b_starts", n_start, 4);
    chk("b2b_consecutive", last_s - first_s, 3);
    chk("b2b_first_out_latency", first_ov - first_s, 31);
    chk("b2b_pops", n_pop, 4);
    chk("b2b_job_done_once", n_jd, 1);
    chk("b2b_job_done_after_pop", jd_cyc - last_pop, 2);
    chk("b2b_scoreboard_empty", eq.size(), 0);
    // Backpressure: 20 operands, consumer stalled
    clr();
    out_ready = 1'b0;
    for (int i = 0; i < 20; i++) feed(32'h4100_0000 + 32'(i * 3));
    start(16'd20);
    repeat (60) tick();
    chk("bp_credit_limit", n_start, 8);
    chk("bp_in_ready_low", in_ready, 0);
    chk("bp_no_pops", n_pop, 0);
    out_ready = 1'b1;
    wait_jd(400);
    repeat (2) tick();
    chk("bp_starts", n_start, 20);
    chk("bp_pops", n_pop, 20);
    chk("bp_job_done_once", n_jd, 1);
    chk("bp_scoreboard_empty", eq.size(), 0);
    // Empty job
    clr();
    start(16'd0);
    repeat (5) tick();
    chk("empty_busy_cycles", n_busy, 1);
    chk("empty_job_done", n_jd, 1);
    chk("empty_no_start", n_start, 0);
    // Capture and pop in the same cycle with 3 buffered; cmd_start during RUN ignored
    clr();
    out_ready = 1'b0;
    feed(32'h3E00_0001); feed(32'h3E00_0002); feed(32'h3E00_0003);
    start(16'd5);
    repeat (45) tick();
    chk("sim_three_issued", n_start, 3);
    start(16'd2);
    feed(32'h3E00_0004);
    wait_start(4, 10);
    s = last_s;
    while (cyc < s + 30) tick();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    repeat (3) tick();
    chk("sim_one_pop", n_pop, 1);
    n_pop = 0;
    out_ready = 1'b1;
    repeat (6) tick();
    chk("sim_count_held_3", n_pop, 3);
    feed(32'h3E00_0005);
    wait_jd(100);
    chk("sim_len_unchanged", n_start, 5);
    chk("sim_scoreboard_empty", eq.size(), 0);
    // Reset with 5 in flight and 2 buffered
    clr();
    out_ready = 1'b0;
    feed(32'h4400_0000); feed(32'h4400_0001);
    start(16'd10);
    repeat (40) tick();
    for (int i = 2; i < 7; i++) feed(32'h4400_0000 + 32'(i));
    wait_start(7, 20);
    repeat (2) tick();
    #2 aclr_n = 1'b0;
    #1;
    chk("midrst_ctrl", {in_ready, fu_start, out_valid, busy, job_done, err, fu_clk_en}, 0);
    chk("midrst_fu_dataa", fu_dataa, 0);
    chk("midrst_out_data", out_data, 0);
    fq.delete();
    eq.delete();
    tick();
    aclr_n = 1'b1;
    repeat (40) tick();
    clr();
    out_ready = 1'b1;
    feed(32'h4500_0000); feed(32'h4500_0001);
    start(16'd2);
    wait_jd(100);
    repeat (2) tick();
    chk("postrst_pops", n_pop, 2);
    chk("postrst_starts", n_start, 2);
    chk("postrst_scoreboard_empty", eq.size(), 0);
`ifdef INNER_SCHED_DONE_CHECK_EN
    clr();
    out_ready = 1'b1;
    early_at = g_cnt + 1;
    feed(32'h3F00_0000); feed(32'h3F00_0001); feed(32'h3F00_0002);
    start(16'd3);
    wait_jd(100);
    chk("done_check_err", err, 1);
    chk("done_check_pops", n_pop, 3);
    repeat (5) tick();
    chk("done_check_err_sticky", err, 1);
`else
    chk("err_tied_low", err, 0);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
